// File: rtl/sisc_seq.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the SISC datapath.
// Owns pc and ir; datapath enables are decoded from the registered state and ir.
module sisc_seq #(
  parameter int unsigned     PC_W   = 16,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic [31:0]     imem_data,
  input  logic [3:0]      stat,
  output logic [PC_W-1:0] imem_addr,
  output logic [31:0]     ir,
  output logic            rf_we,
  output logic [1:0]      alu_op,
  output logic            wb_sel,
  output logic            stat_en,
  output logic            rb_sel,
  output logic            dm_we,
  output logic            halted,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd7
  } state_t;

  localparam logic [3:0] OP_ALUR = 4'h1;
  localparam logic [3:0] OP_ALUI = 4'h2;
  localparam logic [3:0] OP_LOD  = 4'h3;
  localparam logic [3:0] OP_STR  = 4'h4;
  localparam logic [3:0] OP_BRA  = 4'h5;
  localparam logic [3:0] OP_BRR  = 4'h6;
  localparam logic [3:0] OP_BNE  = 4'h7;
  localparam logic [3:0] OP_BNR  = 4'h8;
  localparam logic [3:0] OP_HLT  = 4'hF;

  state_t                  state_q, state_d;
  logic [PC_W-1:0]         pc_q, pc_d;
  logic [31:0]             ir_q, ir_d;

  logic [3:0]              opcode;
  logic [3:0]              mm;
  logic                    taken;
  logic signed [15:0]      br_off16;
  logic [PC_W-1:0]         br_off;

  assign opcode   = ir_q[31:28];
  assign mm       = ir_q[27:24];
  assign br_off16 = ir_q[15:0];
  // Signed size cast sign-extends the 16-bit displacement to the pc width.
  assign br_off   = PC_W'(br_off16);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BRA, OP_BRR: taken = (mm == 4'd0) || ((mm & stat) != 4'd0);
      OP_BNE, OP_BNR: taken = ((mm & stat) == 4'd0);
      default:        taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        ir_d    = imem_data;
        pc_d    = pc_q + PC_W'(1);
        state_d = ST_DECODE;
      end
      ST_DECODE: state_d = (opcode == OP_HLT) ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE: begin
        // pc already points past this instruction, so relative branches add to it.
        if (taken) begin
          case (opcode)
            OP_BRA, OP_BNE: pc_d = ir_q[PC_W-1:0];
            OP_BRR, OP_BNR: pc_d = pc_q + br_off;
            default:        pc_d = pc_q;
          endcase
        end
        state_d = ST_MEM;
      end
      ST_MEM:  state_d = ST_WB;
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q <= ST_START;
      pc_q    <= RST_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    rf_we   = 1'b0;
    alu_op  = 2'b00;
    wb_sel  = 1'b0;
    stat_en = 1'b0;
    rb_sel  = 1'b0;
    dm_we   = 1'b0;
    halted  = 1'b0;
    case (state_q)
      ST_EXECUTE: begin
        case (opcode)
          OP_ALUR: stat_en = 1'b1;
          OP_ALUI: begin
            alu_op  = 2'b01;
            stat_en = 1'b1;
          end
          OP_LOD: alu_op = 2'b11;
          OP_STR: begin
            alu_op = 2'b11;
            rb_sel = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        case (opcode)
          OP_LOD: alu_op = 2'b11;
          OP_STR: begin
            alu_op = 2'b11;
            rb_sel = 1'b1;
            dm_we  = 1'b1;
          end
          default: ;
        endcase
      end
      ST_WB: begin
        case (opcode)
          OP_ALUR, OP_ALUI: begin
            rf_we  = 1'b1;
            wb_sel = 1'b1;
          end
          OP_LOD:  rf_we = 1'b1;
          default: ;
        endcase
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign state     = state_q;

endmodule

// File: tb/tb_sisc_seq.sv
// Scoreboard bench for sisc_seq: an instruction-level model queues per-cycle
// expectations while a driver applies stimulus and a monitor compares outputs.
module tb_sisc_seq;

  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_MEM   = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd7;

  logic        clk = 1'b0;
  logic        rst_f;
  logic [31:0] imem_data;
  logic [3:0]  stat;
  logic [15:0] imem_addr;
  logic [31:0] ir;
  logic        rf_we;
  logic [1:0]  alu_op;
  logic        wb_sel;
  logic        stat_en;
  logic        rb_sel;
  logic        dm_we;
  logic        halted;
  logic [2:0]  dut_state;

  logic [31:0] mem [0:65535];

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];

  sisc_seq #(.PC_W(16), .RST_PC(16'h0000)) dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .imem_data (imem_data),
    .stat      (stat),
    .imem_addr (imem_addr),
    .ir        (ir),
    .rf_we     (rf_we),
    .alu_op    (alu_op),
    .wb_sel    (wb_sel),
    .stat_en   (stat_en),
    .rb_sel    (rb_sel),
    .dm_we     (dm_we),
    .halted    (halted),
    .state     (dut_state)
  );

  typedef struct {
    logic       rst_f;
    logic [3:0] stat;
  } stim_t;

  typedef struct {
    logic [2:0]  st;
    logic [15:0] pc;
    logic [31:0] ir;
    logic        rf_we;
    logic [1:0]  alu_op;
    logic        wb_sel;
    logic        stat_en;
    logic        rb_sel;
    logic        dm_we;
    logic        halted;
  } exp_t;

  stim_t       stim_q[$];
  exp_t        exp_q[$];
  logic [15:0] m_pc;
  logic [31:0] m_ir;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  // Expected datapath controls for one cycle, from the instruction class and phase.
  function automatic exp_t expect_for(input logic [2:0] st);
    exp_t       e;
    logic [3:0] op;
    op        = m_ir[31:28];
    e.st      = st;
    e.pc      = m_pc;
    e.ir      = m_ir;
    e.rf_we   = 1'b0;
    e.alu_op  = 2'b00;
    e.wb_sel  = 1'b0;
    e.stat_en = 1'b0;
    e.rb_sel  = 1'b0;
    e.dm_we   = 1'b0;
    e.halted  = (st == S_HALT);
    if (st == S_EXEC || st == S_MEM) begin
      if (op == 4'h3 || op == 4'h4) e.alu_op = 2'b11;
      if (op == 4'h4) e.rb_sel = 1'b1;
      if (st == S_EXEC && op == 4'h1) e.stat_en = 1'b1;
      if (st == S_EXEC && op == 4'h2) begin
        e.alu_op  = 2'b01;
        e.stat_en = 1'b1;
      end
      if (st == S_MEM && op == 4'h4) e.dm_we = 1'b1;
    end
    if (st == S_WB) begin
      if (op == 4'h1 || op == 4'h2) begin
        e.rf_we  = 1'b1;
        e.wb_sel = 1'b1;
      end
      if (op == 4'h3) e.rf_we = 1'b1;
    end
    return e;
  endfunction

  task automatic push(input logic r, input logic [3:0] s, input logic [2:0] st);
    stim_t t;
    t.rst_f = r;
    t.stat  = s;
    stim_q.push_back(t);
    exp_q.push_back(expect_for(st));
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      m_pc = 16'h0000;
      m_ir = 32'h0;
      push(1'b0, rnd4(), S_START);
    end
    push(1'b1, rnd4(), S_FETCH);
  endtask

  task automatic do_halt(input int n);
    repeat (n) push(1'b1, rnd4(), S_HALT);
  endtask

  task automatic apply_branch(input logic [3:0] s);
    logic [3:0] op, msk;
    logic       tk;
    op  = m_ir[31:28];
    msk = m_ir[27:24] & s;
    tk  = ((op == 4'h5 || op == 4'h6) && (m_ir[27:24] == 4'h0 || msk != 4'h0)) ||
          ((op == 4'h7 || op == 4'h8) && msk == 4'h0);
    if (tk) begin
      if (op == 4'h5 || op == 4'h7) m_pc = m_ir[15:0];
      else m_pc = 16'((int'(m_pc) + int'($signed(m_ir[15:0]))) & 32'hFFFF);
    end
  endtask

  // Starts in FETCH; abort_at = k replaces the k-th edge of the instruction with a reset.
  task automatic do_instr(input int abort_at, input logic [3:0] xstat);
    for (int k = 1; k <= 5; k++) begin
      if (k == abort_at) begin
        do_reset(2);
        return;
      end
      case (k)
        1: begin
          m_ir = mem[m_pc];
          m_pc = m_pc + 16'd1;
          push(1'b1, rnd4(), S_DEC);
          if (m_ir[31:28] == 4'hF) begin
            push(1'b1, rnd4(), S_HALT);
            return;
          end
        end
        2: push(1'b1, rnd4(), S_EXEC);
        3: begin
          apply_branch(xstat);
          push(1'b1, xstat, S_MEM);
        end
        4: push(1'b1, rnd4(), S_WB);
        default: push(1'b1, rnd4(), S_FETCH);
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic run_segment();
    int n;
    n = stim_q.size();
    fork
      begin
        for (int i = 0; i < n; i++) begin
          stim_t t;
          t     = stim_q.pop_front();
          rst_f = t.rst_f;
          stat  = t.stat;
          @(posedge clk);
          #1;
        end
      end
      begin
        for (int i = 0; i < n; i++) begin
          exp_t e;
          @(negedge clk);
          cyc++;
          e = exp_q.pop_front();
          chk("state",   32'(dut_state), 32'(e.st));
          chk("pc",      32'(imem_addr), 32'(e.pc));
          chk("ir",      ir,             e.ir);
          chk("rf_we",   32'(rf_we),     32'(e.rf_we));
          chk("alu_op",  32'(alu_op),    32'(e.alu_op));
          chk("wb_sel",  32'(wb_sel),    32'(e.wb_sel));
          chk("stat_en", 32'(stat_en),   32'(e.stat_en));
          chk("rb_sel",  32'(rb_sel),    32'(e.rb_sel));
          chk("dm_we",   32'(dm_we),     32'(e.dm_we));
          chk("halted",  32'(halted),    32'(e.halted));
        end
      end
    join
  endtask

  initial begin
    rst_f = 1'b0;
    stat  = 4'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;

    mem[0] = 32'h11312000;
    mem[1] = 32'h30200004;
    mem[2] = 32'h40300008;
    mem[3] = 32'h21400010;
    mem[4] = 32'h6100FFFC;
    mem[5] = 32'h71000020;
    mem[6] = 32'h5000FFFF;
    do_reset(2);
    for (int i = 0; i < 4; i++) do_instr(0, rnd4());
    do_instr(0, 4'b0001);
    for (int i = 0; i < 3; i++) do_instr(0, rnd4());
    do_instr(0, 4'b0000);
    do_instr(0, 4'b0001);
    do_instr(0, rnd4());
    do_instr(0, rnd4());
    do_instr(3, rnd4());
    do_instr(0, rnd4());
    do_instr(0, rnd4());
    run_segment();

    mem[2] = 32'hF0000000;
    do_reset(2);
    do_instr(0, rnd4());
    do_instr(0, rnd4());
    do_instr(0, rnd4());
    do_halt(10);
    do_reset(2);
    do_instr(0, rnd4());
    run_segment();

    for (int i = 0; i < 64; i++) begin
      logic [3:0]  op, mm;
      logic [15:0] low;
      op  = 4'($urandom_range(0, 14));
      mm  = ($urandom_range(0, 3) == 0) ? 4'h0 : rnd4();
      low = 16'($urandom);
      if (op == 4'h5 || op == 4'h7) low = 16'($urandom_range(0, 63));
      if (op == 4'h6 || op == 4'h8) low = 16'($urandom_range(0, 16)) - 16'd8;
      mem[i] = {op, mm, 8'($urandom), low};
    end
    do_reset(2);
    repeat (150) begin
      int ab;
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 5)) : 0;
      do_instr(ab, rnd4());
    end
    run_segment();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
